axi_lite_slv_mem: RTL and testbench

AXI_LITE_SLV_MEM -- requirements
Module: axi_lite_slv_mem

---
 rtl/axi_lite_slv_mem.sv | 153 +++++++++++++++
 tb/tb_axi_lite_slv_mem.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slv_mem.sv
// AXI4-Lite slave endpoint backed by a DEPTH x 32 register memory.
// Optional macro AXI_LITE_SLV_MEM_ADDR_ERR_EN: out-of-range accesses get SLVERR instead of aliasing.
module axi_lite_slv_mem #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NBYTE = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rdy_en;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NBYTE-1:0]    r_wstrb;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [1:0]          r_bresp;
  logic [1:0]          r_rresp;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdat;
  logic [NBYTE-1:0]    w_wstb;
  logic [IDX_W-1:0]    w_widx;
  logic [IDX_W-1:0]    w_ridx;
  logic                w_werr;
  logic                w_rerr;
  logic                w_unused;

  assign awready = r_rdy_en & ((r_state == S_IDLE) | (r_state == S_W));
  assign wready  = r_rdy_en & ((r_state == S_IDLE) | (r_state == S_AW));
  assign bvalid  = (r_state == S_RESP);
  assign bresp   = r_bresp;
  assign arready = r_rdy_en & ~r_rvalid;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  assign w_aw_hs = awvalid & awready;
  assign w_w_hs  = wvalid & wready;
  assign w_ar_hs = arvalid & arready;

  // Commit on the edge completing whichever of AW/W handshakes comes last
  assign w_commit = ((r_state == S_IDLE) & w_aw_hs & w_w_hs) |
                    ((r_state == S_AW) & w_w_hs) |
                    ((r_state == S_W) & w_aw_hs);

  assign w_waddr = w_aw_hs ? awaddr : r_awaddr;
  assign w_wdat  = w_w_hs ? wdata : r_wdata;
  assign w_wstb  = w_w_hs ? wstrb : r_wstrb;
  assign w_widx  = w_waddr[IDX_W+1:2];
  assign w_ridx  = araddr[IDX_W+1:2];

`ifdef AXI_LITE_SLV_MEM_ADDR_ERR_EN
  function automatic logic f_out_of_range(input logic [ADDR_W-1:0] a);
    return (a >> (IDX_W + 2)) != '0;
  endfunction
  assign w_werr = f_out_of_range(w_waddr);
  assign w_rerr = f_out_of_range(araddr);
`else
  assign w_werr = 1'b0;
  assign w_rerr = 1'b0;
`endif

  // Byte-offset and aliased upper address bits carry no meaning for the memory
  assign w_unused = ^{w_waddr, araddr};

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_aw_hs && w_w_hs) w_state_nxt = S_RESP;
        else if (w_aw_hs)      w_state_nxt = S_AW;
        else if (w_w_hs)       w_state_nxt = S_W;
      end
      S_AW:    if (w_w_hs)  w_state_nxt = S_RESP;
      S_W:     if (w_aw_hs) w_state_nxt = S_RESP;
      S_RESP:  if (bready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_aw_hs) r_awaddr <= awaddr;
    if (w_w_hs) begin
      r_wdata <= wdata;
      r_wstrb <= wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdy_en <= 1'b0;
      r_bresp  <= 2'b00;
      r_rresp  <= 2'b00;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_commit) begin
        r_bresp <= w_werr ? 2'b10 : 2'b00;
        if (!w_werr) begin
          for (int b = 0; b < NBYTE; b++)
            if (w_wstb[b]) r_mem[w_widx][8*b +: 8] <= w_wdat[8*b +: 8];
        end
      end
      // Nonblocking read sees the pre-write word when a commit lands on the same edge
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rerr ? '0 : r_mem[w_ridx];
        r_rresp  <= w_rerr ? 2'b10 : 2'b00;
      end else if (rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_slv_mem.sv
// Scoreboard bench for axi_lite_slv_mem: drivers queue expected B/R responses, a negedge monitor checks them.
module tb_axi_lite_slv_mem;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  axi_lite_slv_mem dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a response handshake is about to occur
  always @(negedge clock) begin
    if (!reset && bvalid === 1'b1 && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
      else chk("bresp", 32'(bresp), 32'(bq.pop_front()));
    end
    if (!reset && rvalid === 1'b1 && rready) begin
      if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
      else begin
        logic [33:0] e;
        e = rq.pop_front();
        chk("rdata", rdata, e[31:0]);
        chk("rresp", 32'(rresp), 32'(e[33:32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic bit rdy_ok(input int which);
    case (which)
      0:       return awready === 1'b1;
      1:       return wready === 1'b1;
      2:       return (awready === 1'b1) && (wready === 1'b1);
      default: return arready === 1'b1;
    endcase
  endfunction

  task automatic wait_rdy(input int which);
    int n = 0;
    while (!rdy_ok(which) && n < 20) begin
      tick;
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // mode 0: AW+W together, 1: AW first, 2: W first; gap = idle cycles between; hold = cycles bready low
  task automatic write_txn(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp, input int mode, input int gap, input int hold);
    bq.push_back(exp);
    bready = (hold == 0);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    if (mode == 1) begin
      awvalid = 1'b1; wait_rdy(0); tick; awvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin chk("aw_blocked", 32'(awready), 32'd0); tick; end
      wvalid = 1'b1; wait_rdy(1);
    end else if (mode == 2) begin
      wvalid = 1'b1; wait_rdy(1); tick; wvalid = 1'b0;
      for (int i = 0; i < gap; i++) begin chk("w_blocked", 32'(wready), 32'd0); tick; end
      awvalid = 1'b1; wait_rdy(0);
    end else begin
      awvalid = 1'b1; wvalid = 1'b1; wait_rdy(2);
    end
    tick;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("b_latency", 32'(bvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("b_hold", 32'({bvalid, bresp, awready, wready}), 32'({1'b1, exp, 2'b00}));
      tick;
    end
    bready = 1'b1;
    tick;
    chk("rdy_after_b", 32'({awready, wready}), 32'd3);
  endtask

  task automatic read_txn(input logic [11:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
    rq.push_back({exp_r, exp_d});
    araddr  = addr;
    arvalid = 1'b1;
    wait_rdy(3);
    tick;
    arvalid = 1'b0;
    chk("r_latency", 32'(rvalid), 32'd1);
    tick;
  endtask

  initial begin
    // Reset with garbage on the valid inputs, which must be ignored
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    tick; tick;
    chk("reset_ctrl", 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    reset = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick;
    chk("rdy_after_reset", 32'({awready, wready, arready}), 32'd7);

    // W three cycles ahead of AW, partial strobes
    write_txn(12'h008, 32'h1122_3344, 4'b0101, 2'b00, 2, 3, 0);
    read_txn(12'h008, 32'h0022_0044, 2'b00);

    // AW and W together, full word
    write_txn(12'h004, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0);
    read_txn(12'h004, 32'hDEAD_BEEF, 2'b00);

    // AW first, top byte only
    write_txn(12'h005, 32'h7700_0000, 4'b1000, 2'b00, 1, 2, 0);
    read_txn(12'h004, 32'h77AD_BEEF, 2'b00);

    // Back-pressure on B for five cycles
    write_txn(12'h010, 32'h1234_5678, 4'hF, 2'b00, 0, 0, 5);
    read_txn(12'h010, 32'h1234_5678, 2'b00);

    // Read and write of the same word on the same edge returns old data
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'h0});
    awaddr = 12'h00C; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; araddr = 12'h00C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_edge_b", 32'(bvalid), 32'd1);
    chk("same_edge_r", 32'(rvalid), 32'd1);
    tick;
    read_txn(12'h00C, 32'hA5A5_A5A5, 2'b00);

    // Address beyond 4*DEPTH
`ifdef AXI_LITE_SLV_MEM_ADDR_ERR_EN
    write_txn(12'h040, 32'hCAFE_F00D, 4'hF, 2'b10, 0, 0, 0);
    read_txn(12'h000, 32'h0, 2'b00);
    read_txn(12'h040, 32'h0, 2'b10);
`else
    write_txn(12'h040, 32'hCAFE_F00D, 4'hF, 2'b00, 0, 0, 0);
    read_txn(12'h000, 32'hCAFE_F00D, 2'b00);
    read_txn(12'h040, 32'hCAFE_F00D, 2'b00);
`endif

    // Reset while a B response is pending: response dropped, memory cleared
    bready = 1'b0;
    awaddr = 12'h000; wdata = 32'h5555_5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pending_b", 32'(bvalid), 32'd1);
    reset = 1'b1;
    tick;
    chk("reset_mid_b", 32'({bvalid, awready, wready, arready}), 32'd0);
    reset = 1'b0;
    tick;
    chk("rdy_after_reset2", 32'({awready, wready, arready, bvalid}), 32'hE);
    bready = 1'b1;
    for (int i = 0; i < 16; i++) read_txn(12'(4 * i), 32'h0, 2'b00);

    repeat (2) tick;
    chk("bq_drained", 32'(bq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
